llm_int8_mixed_accum: RTL



---
 rtl/llm_int8_mixed_accum.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/llm_int8_mixed_accum.sv
// Mixed-precision matrix-vector accumulator: outliers take an exact product path,
// inliers a quantised int8 path, both summed over IN_DEPTH beats per row.
module llm_int8_mixed_accum #(
    parameter int IN_WIDTH       = 16,
    parameter int WEIGHT_WIDTH   = 16,
    parameter int IN_SIZE        = 4,
    parameter int IN_PARALLELISM = 2,
    parameter int IN_DEPTH       = 3,
    parameter int THRESHOLD      = 127,
    parameter int LOW_WIDTH      = 8,
    parameter int W_SHIFT        = 4,
    parameter bit LOW_PATH_EN    = 1'b1,
    parameter int OUT_WIDTH      = IN_WIDTH + WEIGHT_WIDTH + $clog2(IN_SIZE * IN_DEPTH) + 1,
    parameter int CNT_WIDTH      = $clog2(IN_SIZE * IN_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  data_in [IN_PARALLELISM*IN_SIZE],
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    input  logic signed [WEIGHT_WIDTH-1:0] weight [IN_SIZE],
    input  logic                        weight_valid,
    output logic                        weight_ready,
    output logic signed [OUT_WIDTH-1:0] data_out [IN_PARALLELISM],
    output logic [CNT_WIDTH-1:0]        outlier_count [IN_PARALLELISM],
    output logic                        data_out_valid,
    input  logic                        data_out_ready
);

    localparam int N_ELEM         = IN_PARALLELISM * IN_SIZE;
    localparam int PROD_WIDTH     = IN_WIDTH + WEIGHT_WIDTH;
    localparam int LOW_PROD_WIDTH = 2 * LOW_WIDTH;
    localparam int BEAT_WIDTH     = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int LOW_MAX        = 2 ** (LOW_WIDTH - 1) - 1;
    localparam int LOW_MIN        = -(2 ** (LOW_WIDTH - 1));
    localparam logic signed [WEIGHT_WIDTH-1:0] W_LOW_MAX = WEIGHT_WIDTH'(LOW_MAX);
    localparam logic signed [WEIGHT_WIDTH-1:0] W_LOW_MIN = WEIGHT_WIDTH'(LOW_MIN);
    localparam logic signed [IN_WIDTH:0]       W_THRESH  = (IN_WIDTH + 1)'(THRESHOLD);

    logic signed [LOW_WIDTH-1:0]  w_wq [IN_SIZE];
    logic                         w_outlier [N_ELEM];
    logic signed [OUT_WIDTH-1:0]  w_hi_prod [N_ELEM];
    logic signed [OUT_WIDTH-1:0]  w_lo_prod [N_ELEM];
    logic signed [OUT_WIDTH-1:0]  w_hi_sum [IN_PARALLELISM];
    logic signed [OUT_WIDTH-1:0]  w_lo_sum [IN_PARALLELISM];
    logic [CNT_WIDTH-1:0]         w_cnt [IN_PARALLELISM];
    logic                         w_last, w_accept_ok, w_fire;

    logic [BEAT_WIDTH-1:0]        r_beat_cnt;
    logic signed [OUT_WIDTH-1:0]  r_hi_acc [IN_PARALLELISM];
    logic signed [OUT_WIDTH-1:0]  r_lo_acc [IN_PARALLELISM];
    logic [CNT_WIDTH-1:0]         r_cnt_acc [IN_PARALLELISM];
    logic signed [OUT_WIDTH-1:0]  r_data_out [IN_PARALLELISM];
    logic [CNT_WIDTH-1:0]         r_cnt_out [IN_PARALLELISM];
    logic                         r_out_valid;

    // Weight quantisation is shared by every row: arithmetic shift then clamp to LOW_WIDTH.
    for (genvar k = 0; k < IN_SIZE; k++) begin : g_wq
        logic signed [WEIGHT_WIDTH-1:0] w_shr;
        assign w_shr   = weight[k] >>> W_SHIFT;
        assign w_wq[k] = (w_shr > W_LOW_MAX) ? LOW_WIDTH'(LOW_MAX) :
                         (w_shr < W_LOW_MIN) ? LOW_WIDTH'(LOW_MIN) :
                         w_shr[LOW_WIDTH-1:0];
    end

    for (genvar e = 0; e < N_ELEM; e++) begin : g_elem
        localparam int K = e % IN_SIZE;
        logic signed [IN_WIDTH:0]          w_x_ext, w_mag;
        logic signed [LOW_WIDTH-1:0]       w_xq;
        logic signed [PROD_WIDTH-1:0]      w_exact;
        logic signed [LOW_PROD_WIDTH-1:0]  w_low;

        // One extra bit so the magnitude of the most negative input is representable.
        assign w_x_ext      = {data_in[e][IN_WIDTH-1], data_in[e]};
        assign w_mag        = w_x_ext[IN_WIDTH] ? -w_x_ext : w_x_ext;
        assign w_outlier[e] = !LOW_PATH_EN || (w_mag > W_THRESH);
        assign w_xq         = data_in[e][LOW_WIDTH-1:0];
        assign w_exact      = PROD_WIDTH'(data_in[e]) * PROD_WIDTH'(weight[K]);
        assign w_low        = LOW_PROD_WIDTH'(w_xq) * LOW_PROD_WIDTH'(w_wq[K]);
        assign w_hi_prod[e] = w_outlier[e] ? OUT_WIDTH'(w_exact) : '0;
        assign w_lo_prod[e] = w_outlier[e] ? '0 : (OUT_WIDTH'(w_low) <<< W_SHIFT);
    end

    // NOTE: combinational blocks use blocking '=' so the running sum is read back
    // within the same evaluation; every output gets a default first so no latch forms.
    always_comb begin
        for (int r = 0; r < IN_PARALLELISM; r++) begin
            w_hi_sum[r] = '0;
            w_lo_sum[r] = '0;
            w_cnt[r]    = '0;
            for (int k = 0; k < IN_SIZE; k++) begin
                w_hi_sum[r] = w_hi_sum[r] + w_hi_prod[r*IN_SIZE+k];
                w_lo_sum[r] = w_lo_sum[r] + w_lo_prod[r*IN_SIZE+k];
                w_cnt[r]    = w_cnt[r] + CNT_WIDTH'(w_outlier[r*IN_SIZE+k]);
            end
        end
    end

    // Only the closing beat of a block needs the output slot, so only it stalls.
    assign w_last        = (r_beat_cnt == BEAT_WIDTH'(IN_DEPTH - 1));
    assign w_accept_ok   = !(w_last && r_out_valid && !data_out_ready);
    assign data_in_ready = weight_valid && w_accept_ok;
    assign weight_ready  = data_in_valid && w_accept_ok;
    assign w_fire        = data_in_valid && weight_valid && w_accept_ok;

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values; all state here is small and reset explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            for (int r = 0; r < IN_PARALLELISM; r++) begin
                r_hi_acc[r]   <= '0;
                r_lo_acc[r]   <= '0;
                r_cnt_acc[r]  <= '0;
                r_data_out[r] <= '0;
                r_cnt_out[r]  <= '0;
            end
        end else begin
            if (r_out_valid && data_out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_fire) begin
                if (w_last) begin
                    r_beat_cnt  <= '0;
                    r_out_valid <= 1'b1;
                    for (int r = 0; r < IN_PARALLELISM; r++) begin
                        r_data_out[r] <= r_hi_acc[r] + r_lo_acc[r] + w_hi_sum[r] + w_lo_sum[r];
                        r_cnt_out[r]  <= r_cnt_acc[r] + w_cnt[r];
                        r_hi_acc[r]   <= '0;
                        r_lo_acc[r]   <= '0;
                        r_cnt_acc[r]  <= '0;
                    end
                end else begin
                    r_beat_cnt <= r_beat_cnt + BEAT_WIDTH'(1);
                    for (int r = 0; r < IN_PARALLELISM; r++) begin
                        r_hi_acc[r]  <= r_hi_acc[r] + w_hi_sum[r];
                        r_lo_acc[r]  <= r_lo_acc[r] + w_lo_sum[r];
                        r_cnt_acc[r] <= r_cnt_acc[r] + w_cnt[r];
                    end
                end
            end
        end
    end

    assign data_out       = r_data_out;
    assign outlier_count  = r_cnt_out;
    assign data_out_valid = r_out_valid;

endmodule
